rule_loader: RTL and testbench

RULE_LOADER -- requirements
Module: rule_loader

---
 rtl/rule_loader.sv | 149 ++++++++++++++
 tb/tb_rule_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_loader.sv
// Purpose : assemble byte-serial host rule frames into one wide rule word and
//           write it to the rule RAM, rejecting malformed frames.
// Latency : last byte accepted in cycle N -> wr_en/wr_addr/wr_data in cycle N+1.
// Backpr. : in_ready drops for the single WRITE cycle only; all other states accept.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   in_data/in_valid/
//   in_last/in_ready     host byte stream, MSB-first, valid/ready handshake
//   wr_en/wr_addr/
//   wr_data              rule RAM write port (one-cycle strobe, held address/data)
//   busy                 a frame is being loaded (gates decision-logic enable)
//   err                  one-cycle pulse per malformed frame
//   rule_count           rules written since reset, saturating at 256
module rule_loader #(
  parameter int RULE_W     = 971,
  parameter int RULE_BYTES = 122
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [RULE_W-1:0] wr_data,
  output logic              busy,
  output logic              err,
  output logic [8:0]        rule_count
);

  localparam int         SHIFT_W   = RULE_BYTES * 8;
  localparam logic [6:0] LAST_BYTE = 7'(RULE_BYTES);
  localparam logic [8:0] COUNT_MAX = 9'd256;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [6:0]         byte_cnt;
  logic [6:0]         byte_cnt_nxt;
  logic [6:0]         byte_cnt_inc;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_nxt;
  logic               accept;
  logic               err_nxt;
  logic               wr_nxt;

  // The first byte ends up in the top 8 bits of the frame; the top 5 bits of
  // the frame are padding and never reach the rule word.
  logic               unused_shift_bits;

  assign in_ready     = (state != WRITE);
  assign busy         = (state != IDLE);
  assign accept       = in_valid & in_ready;
  assign shift_nxt    = {shift_q[SHIFT_W-9:0], in_data};
  assign byte_cnt_inc = byte_cnt + 7'd1;

  assign unused_shift_bits = ^{shift_q[SHIFT_W-1 -: 8], shift_nxt[SHIFT_W-1:RULE_W]};

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    err_nxt      = 1'b0;
    wr_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            // A one-byte frame can never be complete.
            err_nxt = 1'b1;
          end else begin
            state_nxt    = COLLECT;
            byte_cnt_nxt = 7'd1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (in_last) begin
            byte_cnt_nxt = 7'd0;
            if (byte_cnt_inc == LAST_BYTE) begin
              state_nxt = WRITE;
              wr_nxt    = 1'b1;
            end else begin
              state_nxt = IDLE;
              err_nxt   = 1'b1;
            end
          end else if (byte_cnt_inc == LAST_BYTE) begin
            // Frame is already full but the host keeps going: flag it now and
            // swallow the tail up to its in_last.
            state_nxt    = DISCARD;
            err_nxt      = 1'b1;
            byte_cnt_nxt = 7'd0;
          end else begin
            byte_cnt_nxt = byte_cnt_inc;
          end
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      DISCARD: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= 7'd0;
      shift_q    <= '0;
      wr_en      <= 1'b0;
      err        <= 1'b0;
      rule_count <= 9'd0;
      wr_addr    <= 8'd0;
      wr_data    <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      err      <= err_nxt;
      wr_en    <= wr_nxt;
      if (accept) begin
        shift_q <= shift_nxt;
      end
      // Capture from the post-shift value so the final byte is included and
      // the write lands in the cycle right after it; the output registers then
      // hold until the next complete frame.
      if (wr_nxt) begin
        wr_data <= shift_nxt[RULE_W-1:0];
        wr_addr <= shift_nxt[RULE_W-1 -: 8];
      end
      if (wr_en && (rule_count != COUNT_MAX)) begin
        rule_count <= rule_count + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_rule_loader.sv
// Purpose : self-checking bench for rule_loader with randomized frames and a
//           frame-level reference model (byte i lands at bits [975-8i -: 8]).
// Ports   : drives clk/rst/in_*; observes every DUT output via a negedge monitor.
module tb_rule_loader;

  localparam int RULE_W     = 971;
  localparam int RULE_BYTES = 122;
  localparam int SHIFT_W    = RULE_BYTES * 8;

  typedef struct packed {
    logic [7:0]        addr;
    logic [RULE_W-1:0] data;
    logic [31:0]       cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [RULE_W-1:0] wr_data;
  logic              busy;
  logic              err;
  logic [8:0]        rule_count;

  rule_loader #(.RULE_W(RULE_W), .RULE_BYTES(RULE_BYTES)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err), .rule_count(rule_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  wr_t  wr_q[$];
  wr_t  exp_wr_q[$];
  int   err_q[$];
  int   exp_err_q[$];
  int   nrdy_cnt = 0;
  int   model_cnt = 0;
  wr_t  exp_last = '0;
  wr_t  mw;
  logic [7:0] fb [0:159];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [RULE_W-1:0] got, input logic [RULE_W-1:0] exp);
    logic [1023:0] gp;
    logic [1023:0] ep;
    gp = 1024'(got);
    ep = 1024'(exp);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_w%0d", tag, k), gp[k*128 +: 128], ep[k*128 +: 128]);
  endtask

  // Monitor: record writes, error pulses and not-ready cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en === 1'b1) begin
        mw.addr = wr_addr;
        mw.data = wr_data;
        mw.cyc  = 32'(cyc);
        wr_q.push_back(mw);
        chk("ready_during_write", 128'(in_ready), 128'(0));
        chk("busy_during_write", 128'(busy), 128'(1));
      end
      if (err === 1'b1) err_q.push_back(cyc);
      if (in_ready !== 1'b1) nrdy_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, output int acc);
    int waited;
    waited   = 0;
    acc      = -1;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      waited++;
      if (waited > 20) begin
        chk("ready_timeout", 128'(in_ready), 128'(1));
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fill(input int len);
    for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
  endtask

  // Rule number field sits at frame bits [970:963]: low 3 bits of byte 0
  // and top 5 bits of byte 1.
  task automatic set_addr(input logic [7:0] a);
    fb[0] = {5'($urandom), a[7:5]};
    fb[1] = {a[4:0], 3'($urandom)};
  endtask

  task automatic send_frame(input int len, input int gap_pct, input bit keep_valid);
    int acc;
    int acc_last;
    int acc_rb;
    logic [SHIFT_W-1:0] word;
    wr_t w;
    acc_rb   = -1;
    acc_last = -1;
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      send_byte(fb[i], (i == len - 1), acc);
      if (i == RULE_BYTES - 1) acc_rb = acc;
      acc_last = acc;
    end
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (len == RULE_BYTES) begin
      word = '0;
      for (int i = 0; i < len; i++) word[SHIFT_W-1-8*i -: 8] = fb[i];
      w.addr = word[RULE_W-1 -: 8];
      w.data = word[RULE_W-1:0];
      w.cyc  = 32'(acc_last + 1);
      exp_wr_q.push_back(w);
      exp_last = w;
      if (model_cnt < 256) model_cnt++;
    end else if (len < RULE_BYTES) begin
      exp_err_q.push_back(acc_last + 1);
    end else begin
      exp_err_q.push_back(acc_rb + 1);
    end
  endtask

  task automatic check_batch(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_nwr"}, 128'(wr_q.size()), 128'(exp_wr_q.size()));
    if (wr_q.size() == exp_wr_q.size()) begin
      for (int i = 0; i < wr_q.size(); i++) begin
        chk({tag, "_addr"}, 128'(wr_q[i].addr), 128'(exp_wr_q[i].addr));
        chk({tag, "_wrcyc"}, 128'(wr_q[i].cyc), 128'(exp_wr_q[i].cyc));
        chk_word({tag, "_data"}, wr_q[i].data, exp_wr_q[i].data);
      end
    end
    chk({tag, "_nerr"}, 128'(err_q.size()), 128'(exp_err_q.size()));
    if (err_q.size() == exp_err_q.size()) begin
      for (int i = 0; i < err_q.size(); i++)
        chk({tag, "_errcyc"}, 128'(err_q[i]), 128'(exp_err_q[i]));
    end
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_count"}, 128'(rule_count), 128'(model_cnt));
    chk({tag, "_hold_addr"}, 128'(wr_addr), 128'(exp_last.addr));
    chk_word({tag, "_hold_data"}, wr_data, exp_last.data);
    chk({tag, "_stalls"}, 128'(nrdy_cnt), 128'(exp_wr_q.size()));
    wr_q.delete();
    exp_wr_q.delete();
    err_q.delete();
    exp_err_q.delete();
    nrdy_cnt = 0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int r;
    int len;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_count", 128'(rule_count), 128'(0));
    chk("rst_addr", 128'(wr_addr), 128'(0));
    chk_word("rst_data", wr_data, '0);
    rst = 1'b0;

    // Single good frame beginning 0x1F, 0xA5
    rand_fill(RULE_BYTES);
    fb[0] = 8'h1F;
    fb[1] = 8'hA5;
    send_frame(RULE_BYTES, 20, 1'b0);
    check_batch("first");
    chk("first_bit970", 128'(wr_data[970]), 128'(1));

    // Early in_last on byte 50
    rand_fill(50);
    send_frame(50, 10, 1'b0);
    check_batch("short50");

    // Overlong frame then a good frame
    rand_fill(130);
    send_frame(130, 10, 1'b0);
    rand_fill(RULE_BYTES);
    set_addr(8'h7C);
    send_frame(RULE_BYTES, 10, 1'b0);
    check_batch("long130");

    // Back-to-back frames with in_valid held high
    rand_fill(RULE_BYTES);
    set_addr(8'h02);
    send_frame(RULE_BYTES, 0, 1'b1);
    rand_fill(RULE_BYTES);
    set_addr(8'h03);
    send_frame(RULE_BYTES, 0, 1'b1);
    check_batch("b2b");

    // One-byte frame
    fb[0] = 8'($urandom);
    send_frame(1, 0, 1'b0);
    check_batch("one_byte");

    // Duplicate address: later frame must be the one held on the outputs
    rand_fill(RULE_BYTES);
    set_addr(8'h55);
    send_frame(RULE_BYTES, 0, 1'b0);
    rand_fill(RULE_BYTES);
    set_addr(8'h55);
    send_frame(RULE_BYTES, 5, 1'b0);
    check_batch("dup");

    // Random mix of good, short and long frames
    for (int f = 0; f < 12; f++) begin
      for (int j = 0; j < 3; j++) begin
        r = $urandom_range(9, 0);
        if (r < 5)       len = RULE_BYTES;
        else if (r == 5) len = 1;
        else if (r < 8)  len = $urandom_range(RULE_BYTES - 1, 2);
        else             len = $urandom_range(RULE_BYTES + 13, RULE_BYTES + 1);
        rand_fill(len);
        send_frame(len, $urandom_range(30, 0), 1'($urandom));
      end
      check_batch("rand");
    end

    // Reset in the middle of a frame
    rand_fill(60);
    for (int i = 0; i < 60; i++) send_byte(fb[i], 1'b0, acc);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 0;
    exp_last  = '0;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ready", 128'(in_ready), 128'(1));
    chk("midrst_count", 128'(rule_count), 128'(0));
    check_batch("midrst");
    rand_fill(RULE_BYTES);
    send_frame(RULE_BYTES, 10, 1'b0);
    check_batch("after_rst");

    // Saturation: 257 more frames on top of the one already counted
    for (int f = 0; f < 257; f++) begin
      rand_fill(RULE_BYTES);
      set_addr(8'(f));
      send_frame(RULE_BYTES, 0, 1'b0);
      check_batch("sat");
    end
    chk("sat_final", 128'(rule_count), 128'(256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
